// File: rtl/mdu_ctrl_pkg.sv
// Shared MDU op encodings, FSM state type and op classification helpers.
// MDU_MADD_EN widens the op to 4 bits; bit 3 picks the unsigned madd/msub variant.
package mdu_ctrl_pkg;

`ifdef MDU_MADD_EN
   localparam int MD_OP_W = 4;
`else
   localparam int MD_OP_W = 3;
`endif

   localparam logic [2:0] MD_MULT  = 3'd0;
   localparam logic [2:0] MD_MULTU = 3'd1;
   localparam logic [2:0] MD_DIV   = 3'd2;
   localparam logic [2:0] MD_DIVU  = 3'd3;
   localparam logic [2:0] MD_MTHI  = 3'd4;
   localparam logic [2:0] MD_MTLO  = 3'd5;
   localparam logic [2:0] MD_MADD  = 3'd6;
   localparam logic [2:0] MD_MSUB  = 3'd7;

   typedef enum logic {ST_IDLE, ST_RUN} md_state_t;

   // Ops that occupy the unit for several cycles and commit a 64-bit result.
   function automatic logic md_is_long(input logic [2:0] op3);
      logic r;
      r = 1'b0;
      case (op3)
         MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: r = 1'b1;
`ifdef MDU_MADD_EN
         MD_MADD, MD_MSUB:                   r = 1'b1;
`endif
         default:                            r = 1'b0;
      endcase
      return r;
   endfunction

   function automatic logic md_is_div(input logic [2:0] op3);
      return (op3 == MD_DIV) || (op3 == MD_DIVU);
   endfunction

endpackage

// File: rtl/mdu_ctrl_calc.sv
// mdu_calc: combinational 64-bit result for mult/div (and madd/msub under MDU_MADD_EN).
// Division by zero substitutes a divisor of 1 to keep the result defined; o_div0 flags it.
module mdu_calc
   import mdu_ctrl_pkg::*;
(
   input  logic [MD_OP_W-1:0] i_op,
   input  logic [31:0]        i_rs,
   input  logic [31:0]        i_rt,
   input  logic [31:0]        i_hi,
   input  logic [31:0]        i_lo,
   output logic [63:0]        o_res,
   output logic               o_div0
);

   logic [63:0]        w_sprod;
   logic [63:0]        w_uprod;
   logic [31:0]        w_dvs;
   logic signed [31:0] w_sq;
   logic signed [31:0] w_sr;
   logic [31:0]        w_uq;
   logic [31:0]        w_ur;

   // Sign-extended operands give the signed product modulo 2^64.
   assign w_sprod = {{32{i_rs[31]}}, i_rs} * {{32{i_rt[31]}}, i_rt};
   assign w_uprod = {32'd0, i_rs} * {32'd0, i_rt};

   assign o_div0 = (i_rt == 32'd0);
   assign w_dvs  = o_div0 ? 32'd1 : i_rt;
   assign w_sq   = $signed(i_rs) / $signed(w_dvs);
   assign w_sr   = $signed(i_rs) % $signed(w_dvs);
   assign w_uq   = i_rs / w_dvs;
   assign w_ur   = i_rs % w_dvs;

   always_comb begin
      o_res = w_sprod;
      case (i_op[2:0])
         MD_MULT:  o_res = w_sprod;
         MD_MULTU: o_res = w_uprod;
         MD_DIV:   o_res = {w_sr, w_sq};
         MD_DIVU:  o_res = {w_ur, w_uq};
`ifdef MDU_MADD_EN
         MD_MADD:  o_res = {i_hi, i_lo} + (i_op[3] ? w_uprod : w_sprod);
         MD_MSUB:  o_res = {i_hi, i_lo} - (i_op[3] ? w_uprod : w_sprod);
`endif
         default:  o_res = w_sprod;
      endcase
   end

`ifndef MDU_MADD_EN
   logic w_unused_hilo;
   assign w_unused_hilo = ^{i_hi, i_lo};
`endif

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: E-stage multiply/divide sequencer holding HI/LO with a fixed-latency busy counter.
// Optional madd/maddu/msub/msubu support is enabled by defining MDU_MADD_EN.
module mdu_ctrl
   import mdu_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               Req,
   input  logic               start,
   input  logic [MD_OP_W-1:0] op,
   input  logic [31:0]        rs_data,
   input  logic [31:0]        rt_data,
   input  logic               d_uses_md,
   output logic               busy,
   output logic               stall_md,
   output logic [31:0]        hi,
   output logic [31:0]        lo
);

   localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   md_state_t          r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_busy;
   logic [31:0]        r_hi;
   logic [31:0]        r_lo;
   logic [63:0]        r_pend;
   logic               r_div0;

   logic [63:0]        w_res;
   logic               w_div0;
   logic               w_long;
   logic               w_div;

   assign w_long = md_is_long(op[2:0]);
   assign w_div  = md_is_div(op[2:0]);

   mdu_calc u_calc (
      .i_op   (op),
      .i_rs   (rs_data),
      .i_rt   (rt_data),
      .i_hi   (r_hi),
      .i_lo   (r_lo),
      .o_res  (w_res),
      .o_div0 (w_div0)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_pend  <= '0;
         r_div0  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               // A flushed (Req) instruction must not touch any state.
               if (start && !Req) begin
                  if (w_long) begin
                     r_pend  <= w_res;
                     r_div0  <= w_div0 & w_div;
                     r_cnt   <= w_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                     r_busy  <= 1'b1;
                     r_state <= ST_RUN;
                  end else if (op[2:0] == MD_MTHI) begin
                     r_hi <= rs_data;
                  end else if (op[2:0] == MD_MTLO) begin
                     r_lo <= rs_data;
                  end
               end
            end
            ST_RUN: begin
               // Issued by an older committed instruction, so Req does not cancel it.
               r_cnt <= r_cnt - 1'b1;
               if (r_cnt == CNT_W'(1)) begin
                  if (!r_div0) begin
                     r_hi <= r_pend[63:32];
                     r_lo <= r_pend[31:0];
                  end
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign stall_md = d_uses_md & (r_busy | (start & w_long));
   assign busy     = r_busy;
   assign hi       = r_hi;
   assign lo       = r_lo;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed cases plus randomized traffic against a timeline model.
module tb_mdu_ctrl;
   import mdu_ctrl_pkg::*;

   localparam int MC = 5;
   localparam int DC = 10;

   logic               clk = 1'b0;
   logic               reset, Req, start, d_uses_md;
   logic [MD_OP_W-1:0] op;
   logic [31:0]        rs_data, rt_data;
   logic               busy, stall_md;
   logic [31:0]        hi, lo;

   mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk(clk), .reset(reset), .Req(Req), .start(start), .op(op),
      .rs_data(rs_data), .rt_data(rt_data), .d_uses_md(d_uses_md),
      .busy(busy), .stall_md(stall_md), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int stall_cnt = 0;

   // Reference model: architectural HI/LO, cycles left until commit, and the value to commit.
   bit [31:0] m_hi, m_lo;
   bit [63:0] m_pend;
   bit        m_commit;
   int        m_left;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit is_long(input logic [MD_OP_W-1:0] o);
      case (o[2:0])
         3'd0, 3'd1, 3'd2, 3'd3: return 1'b1;
`ifdef MDU_MADD_EN
         3'd6, 3'd7: return 1'b1;
`endif
         default: return 1'b0;
      endcase
   endfunction

   task automatic model_issue(input logic [MD_OP_W-1:0] o, input bit [31:0] a, input bit [31:0] b);
      longint sa, sb;
      longint unsigned ua, ub;
      int ia, ib;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      ia = a;
      ib = b;
      m_commit = 1'b1;
      m_left   = MC;
      case (o[2:0])
         3'd0: m_pend = sa * sb;
         3'd1: m_pend = ua * ub;
         3'd2: begin
            m_left = DC;
            if (b == 0) m_commit = 1'b0;
            else m_pend = {32'(ia % ib), 32'(ia / ib)};
         end
         3'd3: begin
            m_left = DC;
            if (b == 0) m_commit = 1'b0;
            else m_pend = {a % b, a / b};
         end
`ifdef MDU_MADD_EN
         3'd6: m_pend = {m_hi, m_lo} + (o[3] ? 64'(ua * ub) : 64'(sa * sb));
         3'd7: m_pend = {m_hi, m_lo} - (o[3] ? 64'(ua * ub) : 64'(sa * sb));
`endif
         default: m_commit = 1'b0;
      endcase
   endtask

   // One clock: drive inputs, check the combinational stall, clock, update model, check registers.
   task automatic cyc(input bit st, input logic [MD_OP_W-1:0] o, input bit [31:0] a,
                      input bit [31:0] b, input bit rq, input bit d, input bit rst);
      bit exp_stall;
      start = st; op = o; rs_data = a; rt_data = b; Req = rq; d_uses_md = d; reset = rst;
      #2;
      exp_stall = d & ((m_left > 0) | (st & is_long(o)));
      chk("stall_md", stall_md, exp_stall);
      if (stall_md === 1'b1) stall_cnt++;
      @(posedge clk);
      if (rst) begin
         m_hi = 0; m_lo = 0; m_left = 0; m_pend = 0; m_commit = 0;
      end else if (m_left > 0) begin
         m_left--;
         if (m_left == 0 && m_commit) {m_hi, m_lo} = m_pend;
      end else if (st && !rq) begin
         if (is_long(o)) model_issue(o, a, b);
         else if (o[2:0] == 3'd4) m_hi = a;
         else if (o[2:0] == 3'd5) m_lo = a;
      end
      #1;
      chk("busy", busy, m_left > 0);
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
      start = 1'b0;
      reset = 1'b0;
   endtask

   task automatic idle(input bit d);
      cyc(1'b0, '0, 32'd0, 32'd0, 1'b0, d, 1'b0);
   endtask

   // Idle until busy drops; returns number of busy cycles observed.
   task automatic drain(input bit d, output int n);
      n = 0;
      while (busy === 1'b1 && n < 40) begin
         n++;
         idle(d);
      end
      if (n >= 40) chk("drain_timeout", n, 0);
   endtask

   initial begin
      int n;
      logic [MD_OP_W-1:0] ro;
      bit [31:0] ra, rb;
      m_hi = 0; m_lo = 0; m_left = 0; m_pend = 0; m_commit = 0;
      start = 0; op = '0; rs_data = 0; rt_data = 0; Req = 0; d_uses_md = 0; reset = 1;
      #1;
      cyc(1'b0, '0, 0, 0, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, '0, 0, 0, 1'b0, 1'b0, 1'b1);
      chk("reset_busy", busy, 0);
      chk("reset_hilo", {hi, lo}, 64'd0);

      // mult -2 * 3
      cyc(1'b1, MD_OP_W'(MD_MULT), 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0, 1'b0);
      drain(1'b0, n);
      chk("mult_busy_len", n, MC);
      chk("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);

      // divu 100/7 with a dependent mflo in D
      stall_cnt = 0;
      cyc(1'b1, MD_OP_W'(MD_DIVU), 32'd100, 32'd7, 1'b0, 1'b1, 1'b0);
      drain(1'b1, n);
      idle(1'b1);
      chk("divu_busy_len", n, DC);
      chk("divu_stall_len", stall_cnt, DC + 1);
      chk("divu_hilo", {hi, lo}, {32'd2, 32'd14});

      // div -7/2, then divide by zero leaves hi/lo alone
      cyc(1'b1, MD_OP_W'(MD_DIV), 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 1'b0);
      drain(1'b0, n);
      chk("div_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      cyc(1'b1, MD_OP_W'(MD_DIV), 32'd1234, 32'd0, 1'b0, 1'b0, 1'b0);
      drain(1'b0, n);
      chk("div0_busy_len", n, DC);
      chk("div0_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

      // mthi flushed, then committed
      cyc(1'b1, MD_OP_W'(MD_MTHI), 32'h1234_5678, 32'd0, 1'b1, 1'b0, 1'b0);
      chk("mthi_req_hi", hi, 32'hFFFF_FFFF);
      cyc(1'b1, MD_OP_W'(MD_MTHI), 32'h1234_5678, 32'd0, 1'b0, 1'b0, 1'b0);
      chk("mthi_hi", hi, 32'h1234_5678);
      chk("mthi_busy", busy, 0);

      // Req pulse on RUN cycle 2 does not cancel the operation
      cyc(1'b1, MD_OP_W'(MD_MULTU), 32'd6, 32'd7, 1'b0, 1'b0, 1'b0);
      idle(1'b0);
      cyc(1'b0, '0, 0, 0, 1'b1, 1'b0, 1'b0);
      drain(1'b0, n);
      chk("req_run_len", n, MC - 2);
      chk("req_run_hilo", {hi, lo}, 64'd42);

      // reset on RUN cycle 3 aborts
      cyc(1'b1, MD_OP_W'(MD_MULT), 32'd9, 32'd9, 1'b0, 1'b0, 1'b0);
      idle(1'b0);
      idle(1'b0);
      cyc(1'b0, '0, 0, 0, 1'b0, 1'b0, 1'b1);
      chk("rst_run_busy", busy, 0);
      chk("rst_run_hilo", {hi, lo}, 64'd0);

      // madd on hi=0, lo=0xFFFFFFFF with 1*1
      cyc(1'b1, MD_OP_W'(MD_MTLO), 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, MD_OP_W'(MD_MADD), 32'd1, 32'd1, 1'b0, 1'b0, 1'b0);
`ifdef MDU_MADD_EN
      chk("madd_busy", busy, 1);
      drain(1'b0, n);
      chk("madd_len", n, MC);
      chk("madd_hilo", {hi, lo}, {32'd1, 32'd0});
`else
      chk("madd_nop_busy", busy, 0);
      idle(1'b0);
      chk("madd_nop_hilo", {hi, lo}, {32'd0, 32'hFFFF_FFFF});
`endif

      // randomized traffic; new starts only issued while the model is idle
      for (int i = 0; i < 400; i++) begin
         ro = MD_OP_W'($urandom);
         ra = $urandom;
         rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 3) == 0) rb = 32'(int'($urandom_range(0, 20)) - 10);
         if (ro[2:0] == 3'd2 && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd1;
         cyc((m_left == 0) && ($urandom_range(0, 2) != 0), ro, ra, rb,
             $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
             $urandom_range(0, 99) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
